rom_dma_fifo_fill: RTL and testbench



---
 rtl/rom_dma_fifo_fill_pkg.sv | 16 +
 rtl/rom_dma_skid_buf.sv | 43 ++++
 rtl/rom_dma_fifo_fill.sv | 126 ++++++++++++
 tb/tb_rom_dma_fifo_fill.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_dma_fifo_fill_pkg.sv
// Shared constants and FSM state type for the ROM-to-FIFO DMA fill stage.
package rom_dma_fifo_fill_pkg;

  localparam int unsigned FIFO_DATA_WIDTH             = 8;
  localparam int unsigned NUM_OF_ROM_FIFO_RD_PER_INST = 3;
  localparam int unsigned SKID_DEPTH                  = 2;
  localparam int unsigned SKID_CNT_W                  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } t_rom_dma_fill_st;

endpackage

// File: rtl/rom_dma_skid_buf.sv
// Two-entry in-order skid buffer that catches ROM read data while the FIFO is full.
module rom_dma_skid_buf
  import rom_dma_fifo_fill_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [SKID_CNT_W-1:0] count,
  output logic [DATA_WIDTH-1:0] head_data_c
);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SKID_DEPTH); i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + SKID_CNT_W'(push) - SKID_CNT_W'(pop);
    end
  end

  assign head_data_c = mem[rd_ptr];

endmodule

// File: rtl/rom_dma_fifo_fill.sv
// DMA fill stage: streams dma_num_inst instructions worth of ROM words into the ROM data
// FIFO in address order, throttling on FIFO full without dropping in-flight ROM data.
module rom_dma_fifo_fill
  import rom_dma_fifo_fill_pkg::t_rom_dma_fill_st, rom_dma_fifo_fill_pkg::IDLE,
         rom_dma_fifo_fill_pkg::FETCH, rom_dma_fifo_fill_pkg::DRAIN,
         rom_dma_fifo_fill_pkg::DONE, rom_dma_fifo_fill_pkg::SKID_CNT_W;
#(
  parameter int unsigned FIFO_DATA_WIDTH             = rom_dma_fifo_fill_pkg::FIFO_DATA_WIDTH,
  parameter int unsigned ROM_ADDR_WIDTH              = 8,
  parameter int unsigned NUM_OF_ROM_FIFO_RD_PER_INST = rom_dma_fifo_fill_pkg::NUM_OF_ROM_FIFO_RD_PER_INST,
  parameter int unsigned INST_CNT_WIDTH              = 6
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       dma_start,
  input  logic                       dma_abort,
  input  logic [ROM_ADDR_WIDTH-1:0]  dma_base_addr,
  input  logic [INST_CNT_WIDTH-1:0]  dma_num_inst,
  output logic                       rom_rd_en,
  output logic [ROM_ADDR_WIDTH-1:0]  rom_addr,
  input  logic [FIFO_DATA_WIDTH-1:0] rom_rd_data,
  output logic                       rom_data_fifo_fifo_data_push,
  output logic [FIFO_DATA_WIDTH-1:0] rom_data_fifo_fifo_data_in,
  input  logic                       rom_data_fifo_fifo_full,
  output logic                       dma_busy,
  output logic                       dma_done,
  output logic [ROM_ADDR_WIDTH:0]    dma_words_sent
);

  localparam int unsigned WL_W = INST_CNT_WIDTH + 2;
  localparam int unsigned WS_W = ROM_ADDR_WIDTH + 1;

  t_rom_dma_fill_st           state;
  t_rom_dma_fill_st           state_nxt;
  logic [WL_W-1:0]            words_left;
  logic [WL_W-1:0]            start_words;
  logic [ROM_ADDR_WIDTH-1:0]  addr;
  logic                       rd_pending;
  logic [SKID_CNT_W-1:0]      skid_count;
  logic [FIFO_DATA_WIDTH-1:0] skid_head;
  logic                       skid_nonempty;
  logic                       pop_skid;
  logic                       direct_push;
  logic                       skid_wr;
  logic                       push_c;
  logic                       rd_en_c;
  logic [2:0]                 credit_used;
  logic [FIFO_DATA_WIDTH-1:0] fifo_data_c;

  // Return path and read credit: skid head wins over direct push to keep order.
  always_comb begin
    start_words   = WL_W'(dma_num_inst) * WL_W'(NUM_OF_ROM_FIFO_RD_PER_INST);
    skid_nonempty = (skid_count != '0);
    pop_skid      = skid_nonempty & ~rom_data_fifo_fifo_full & ~dma_abort;
    direct_push   = rd_pending & ~skid_nonempty & ~rom_data_fifo_fifo_full & ~dma_abort;
    skid_wr       = rd_pending & ~direct_push & ~dma_abort;
    push_c        = pop_skid | direct_push;
    credit_used   = 3'(rd_pending) + 3'(skid_count) - 3'(pop_skid);
    rd_en_c       = (state == FETCH) & (words_left != '0) & (credit_used < 3'd2) & ~dma_abort;
    fifo_data_c   = '0;
    if (pop_skid)         fifo_data_c = skid_head;
    else if (direct_push) fifo_data_c = rom_rd_data;
  end

  always_comb begin
    state_nxt = state;
    if (dma_abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (dma_start) state_nxt = (start_words == '0) ? DONE : FETCH;
        FETCH:   if (rd_en_c && (words_left == WL_W'(1))) state_nxt = DRAIN;
        DRAIN:   if (!rd_pending && !skid_nonempty) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      words_left     <= '0;
      addr           <= '0;
      rd_pending     <= 1'b0;
      dma_busy       <= 1'b0;
      dma_done       <= 1'b0;
      dma_words_sent <= '0;
    end else begin
      state      <= state_nxt;
      rd_pending <= rd_en_c;
      dma_busy   <= (state_nxt == FETCH) || (state_nxt == DRAIN);
      dma_done   <= (state == DONE) && !dma_abort;
      if ((state == IDLE) && dma_start && !dma_abort) begin
        words_left     <= start_words;
        addr           <= dma_base_addr;
        dma_words_sent <= '0;
      end else begin
        if (rd_en_c) begin
          words_left <= words_left - WL_W'(1);
          addr       <= addr + ROM_ADDR_WIDTH'(1);
        end
        if (push_c) dma_words_sent <= dma_words_sent + WS_W'(1);
      end
    end
  end

  rom_dma_skid_buf #(
    .DATA_WIDTH (FIFO_DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (dma_abort),
    .push        (skid_wr),
    .push_data   (rom_rd_data),
    .pop         (pop_skid),
    .count       (skid_count),
    .head_data_c (skid_head)
  );

  assign rom_rd_en                    = rd_en_c;
  assign rom_addr                     = addr;
  assign rom_data_fifo_fifo_data_push = push_c;
  assign rom_data_fifo_fifo_data_in   = fifo_data_c;

endmodule

// File: tb/tb_rom_dma_fifo_fill.sv
// Bench for rom_dma_fifo_fill: ROM model, address/data scoreboard, vector table,
// randomized transfers and hand-written abort/reset sequences.
module tb_rom_dma_fifo_fill;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 8;
  localparam int unsigned NPI = 3;
  localparam int unsigned IW  = 6;

  logic          clk;
  logic          reset_n;
  logic          dma_start;
  logic          dma_abort;
  logic [AW-1:0] dma_base_addr;
  logic [IW-1:0] dma_num_inst;
  logic          rom_rd_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_rd_data;
  logic          push;
  logic [DW-1:0] data_in;
  logic          fifo_full;
  logic          dma_busy;
  logic          dma_done;
  logic [AW:0]   dma_words_sent;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] rom_mem [256];
  logic [AW-1:0] exp_addr_q [$];
  logic [DW-1:0] exp_data_q [$];
  int exp_n, reads_seen, push_seen, done_seen;
  int first_rd_cyc, last_rd_cyc, first_push_cyc, done_cyc, start_cyc;

  typedef struct {
    logic [7:0] base;
    logic [5:0] num;
    int         mode;
    int         exp_words;
    bit         chk_timing;
    bit         rnd_start;
  } vec_t;
  vec_t vecs [6];

  rom_dma_fifo_fill #(
    .FIFO_DATA_WIDTH             (DW),
    .ROM_ADDR_WIDTH              (AW),
    .NUM_OF_ROM_FIFO_RD_PER_INST (NPI),
    .INST_CNT_WIDTH              (IW)
  ) dut (
    .clk                          (clk),
    .reset_n                      (reset_n),
    .dma_start                    (dma_start),
    .dma_abort                    (dma_abort),
    .dma_base_addr                (dma_base_addr),
    .dma_num_inst                 (dma_num_inst),
    .rom_rd_en                    (rom_rd_en),
    .rom_addr                     (rom_addr),
    .rom_rd_data                  (rom_rd_data),
    .rom_data_fifo_fifo_data_push (push),
    .rom_data_fifo_fifo_data_in   (data_in),
    .rom_data_fifo_fifo_full      (fifo_full),
    .dma_busy                     (dma_busy),
    .dma_done                     (dma_done),
    .dma_words_sent               (dma_words_sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ROM: data valid exactly one cycle after the strobe, garbage otherwise.
  always @(posedge clk) rom_rd_data <= rom_rd_en ? rom_mem[rom_addr] : 8'($urandom);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: reads must walk base..base+n-1 and pushes must carry ROM data in that order.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rom_rd_en) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        last_rd_cyc = cyc;
        reads_seen++;
        if (exp_addr_q.size() == 0) check("rd_beyond_len", 32'(reads_seen), 32'(exp_n));
        else                        check("rd_addr", 32'(rom_addr), 32'(exp_addr_q.pop_front()));
      end
      if (push) begin
        if (first_push_cyc < 0) first_push_cyc = cyc;
        push_seen++;
        check("push_while_full", 32'(fifo_full), 32'd0);
        if (exp_data_q.size() == 0) check("push_beyond_len", 32'(push_seen), 32'(exp_n));
        else                        check("push_data", 32'(data_in), 32'(exp_data_q.pop_front()));
      end
      if (dma_done) begin
        done_seen++;
        done_cyc = cyc;
      end
    end
  end

  task automatic load_model(input logic [7:0] base, input logic [5:0] num);
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_n = int'(num) * int'(NPI);
    for (int i = 0; i < exp_n; i++) begin
      exp_addr_q.push_back(8'(int'(base) + i));
      exp_data_q.push_back(rom_mem[8'(int'(base) + i)]);
    end
    reads_seen = 0; push_seen = 0; done_seen = 0;
    first_rd_cyc = -1; last_rd_cyc = -1; first_push_cyc = -1; done_cyc = -1;
  endtask

  task automatic start_pulse(input logic [7:0] base, input logic [5:0] num);
    @(posedge clk); #1;
    dma_base_addr = base;
    dma_num_inst  = num;
    dma_start     = 1'b1;
    start_cyc     = cyc;
    @(posedge clk); #1;
    dma_start     = 1'b0;
    dma_base_addr = 8'($urandom);
    dma_num_inst  = 6'($urandom);
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_rd_en"},  32'(rom_rd_en), 32'd0);
    check({tag, "_addr"},   32'(rom_addr), 32'd0);
    check({tag, "_push"},   32'(push), 32'd0);
    check({tag, "_data"},   32'(data_in), 32'd0);
    check({tag, "_busy"},   32'(dma_busy), 32'd0);
    check({tag, "_done"},   32'(dma_done), 32'd0);
    check({tag, "_wsent"},  32'(dma_words_sent), 32'd0);
  endtask

  // mode 0: never full, 1: random full, 2: full 5 clks after 2nd read, 3: full 30 clks after 1st read
  task automatic run_xfer(input logic [7:0] base, input logic [5:0] num, input int mode,
                          input int exp_words, input bit chk_timing, input bit rnd_start);
    int budget;
    int hold;
    load_model(base, num);
    start_pulse(base, num);
    budget = 0;
    hold   = 0;
    while (done_seen == 0 && budget < 3000) begin
      fifo_full = 1'b0;
      case (mode)
        1: fifo_full = ($urandom_range(0, 99) < 35);
        2: if (reads_seen >= 2 && hold < 5) begin fifo_full = 1'b1; hold++; end
        3: if (reads_seen >= 1 && hold < 30) begin
             fifo_full = 1'b1;
             hold++;
             if (hold == 30) begin
               check("hold_busy", 32'(dma_busy), 32'd1);
               check("hold_no_push", 32'(push_seen), 32'd0);
             end
           end
        default: ;
      endcase
      dma_start = 1'b0;
      if (rnd_start && dma_busy && $urandom_range(0, 9) == 0) begin
        dma_start     = 1'b1;
        dma_base_addr = 8'($urandom);
        dma_num_inst  = 6'($urandom);
      end
      @(posedge clk); #1;
      budget++;
    end
    dma_start = 1'b0;
    fifo_full = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("done_pulses", 32'(done_seen), 32'd1);
    check("words_sent", 32'(dma_words_sent), 32'(exp_words));
    check("push_count", 32'(push_seen), 32'(exp_words));
    check("read_count", 32'(reads_seen), 32'(exp_words));
    check("busy_after_done", 32'(dma_busy), 32'd0);
    if (chk_timing) begin
      if (exp_words == 0) begin
        check("done_latency", 32'(done_cyc - start_cyc), 32'd2);
      end else begin
        check("first_rd_lat", 32'(first_rd_cyc - start_cyc), 32'd1);
        check("first_push_lat", 32'(first_push_cyc - first_rd_cyc), 32'd1);
        check("rd_burst_span", 32'(last_rd_cyc - first_rd_cyc), 32'(exp_words - 1));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    int num;
    reset_n = 1'b0; dma_start = 1'b0; dma_abort = 1'b0; fifo_full = 1'b0;
    dma_base_addr = '0; dma_num_inst = '0;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
    load_model(8'h00, 6'd0);
    #3;
    check_outs_zero("reset");
    #19 reset_n = 1'b1;

    vecs[0] = '{8'h10, 6'd2,  0, 6,   1'b1, 1'b0};
    vecs[1] = '{8'h00, 6'd0,  0, 0,   1'b1, 1'b0};
    vecs[2] = '{8'hFE, 6'd1,  0, 3,   1'b1, 1'b0};
    vecs[3] = '{8'h40, 6'd3,  2, 9,   1'b0, 1'b0};
    vecs[4] = '{8'h80, 6'd4,  3, 12,  1'b0, 1'b1};
    vecs[5] = '{8'hF0, 6'd63, 1, 189, 1'b0, 1'b1};
    for (int v = 0; v < 6; v++)
      run_xfer(vecs[v].base, vecs[v].num, vecs[v].mode, vecs[v].exp_words,
               vecs[v].chk_timing, vecs[v].rnd_start);

    for (int r = 0; r < 8; r++) begin
      num = $urandom_range(0, 8);
      run_xfer(8'($urandom), 6'(num), 1, num * int'(NPI), 1'b0, 1'b1);
    end

    // Abort in FETCH with a read in flight after four pushes.
    load_model(8'h30, 6'd3);
    start_pulse(8'h30, 6'd3);
    budget = 0;
    while (push_seen < 4 && budget < 50) begin @(posedge clk); #1; budget++; end
    check("abort_setup", 32'(push_seen), 32'd4);
    dma_abort = 1'b1;
    @(posedge clk); #1;
    dma_abort = 1'b0;
    check("abort_busy", 32'(dma_busy), 32'd0);
    repeat (5) begin @(posedge clk); #1; end
    check("abort_pushes", 32'(push_seen), 32'd4);
    check("abort_reads", 32'(reads_seen), 32'd5);
    check("abort_wsent", 32'(dma_words_sent), 32'd4);
    check("abort_no_done", 32'(done_seen), 32'd0);
    run_xfer(8'h22, 6'd2, 0, 6, 1'b1, 1'b0);

    // Start and abort together in IDLE: abort wins.
    load_model(8'h60, 6'd2);
    @(posedge clk); #1;
    dma_base_addr = 8'h60; dma_num_inst = 6'd2; dma_start = 1'b1; dma_abort = 1'b1;
    @(posedge clk); #1;
    dma_start = 1'b0; dma_abort = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("sa_reads", 32'(reads_seen), 32'd0);
    check("sa_busy", 32'(dma_busy), 32'd0);
    check("sa_done", 32'(done_seen), 32'd0);
    check("sa_wsent", 32'(dma_words_sent), 32'd6);

    // Async reset in DRAIN with both skid entries occupied.
    load_model(8'h50, 6'd1);
    start_pulse(8'h50, 6'd1);
    budget = 0;
    while (reads_seen < 2 && budget < 50) begin @(posedge clk); #1; budget++; end
    fifo_full = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("drain_reads", 32'(reads_seen), 32'd3);
    check("drain_pushes", 32'(push_seen), 32'd1);
    check("drain_busy", 32'(dma_busy), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_outs_zero("async_rst");
    @(posedge clk); #3;
    reset_n   = 1'b1;
    fifo_full = 1'b0;
    run_xfer(8'hA0, 6'd2, 1, 6, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
